load_store_unit: RTL and testbench

Parametrised, multi-cycle load/store and writeback-select unit for the RISKY core. It sits between the execute stage (ALU result, rs2, instruction word) and the data memory port. It generates byte-lane-aligned memory requests over a ready/valid handshake and extracts and extends load data. It also selects the register-file writeback value (LUI immediate, load data or ALU result) and reports misaligned, illegal and timeout faults.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_load_align.sv | 39 +++
 rtl/load_store_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared opcode/funct3 constants, FSM state and fault-cause types
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        FC_MISALIGN = 2'd0,
        FC_ILLEGAL  = 2'd1,
        FC_TIMEOUT  = 2'd2
    } fault_cause_t;

    // Access size in bytes; funct3[1:0] encodes log2 of the size.
    function automatic logic [3:0] size_from_funct3(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module      : lsu_load_align
// Description : Extracts the addressed bytes of a read word and extends them
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [OFFW-1:0] off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] wb_o
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        wb_o = w_shifted;
        case (funct3_i)
            F3_B:    wb_o = XLEN'($signed(w_shifted[7:0]));
            F3_H:    wb_o = XLEN'($signed(w_shifted[15:0]));
            F3_W:    wb_o = XLEN'($signed(w_shifted[31:0]));
            F3_BU:   wb_o = XLEN'(w_shifted[7:0]);
            F3_HU:   wb_o = XLEN'(w_shifted[15:0]);
            F3_WU:   wb_o = XLEN'(w_shifted[31:0]);
            default: wb_o = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store + writeback select with fault reporting
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [31:0]         inst,
    input  logic [XLEN-1:0]     aluin,
    input  logic [XLEN-1:0]     rs2_data,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                done,
    output logic                werf,
    output logic [XLEN-1:0]     wb_data,
    output logic                fault,
    output logic [1:0]          fault_cause
);

    localparam int          c_NBYTES = XLEN/8;
    localparam int          c_OFFW   = $clog2(c_NBYTES);
    localparam logic [31:0] c_TLIM   = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    lsu_state_t          state_q, state_d;
    fault_cause_t        cause_q, cause_d;
    logic [31:0]         tcnt_q, tcnt_d;
    logic [XLEN-1:0]     addr_q, addr_d, wdata_q, wdata_d, wb_q, wb_d;
    logic [c_NBYTES-1:0] be_q, be_d;
    logic [c_OFFW-1:0]   off_q, off_d;
    logic [2:0]          f3_q, f3_d;
    logic                we_q, we_d, werf_q, werf_d, fault_q, fault_d;
    logic                done_q, req_q, busy_q;

    logic [6:0]          w_opc;
    logic [2:0]          w_f3;
    logic [3:0]          w_size;
    logic [2:0]          w_mask;
    logic [c_OFFW-1:0]   w_off;
    logic                w_illegal, w_misaligned, w_tmo;
    logic [c_NBYTES-1:0] w_be;
    logic [XLEN-1:0]     w_wdata, w_load_wb;
    logic                w_unused;

    assign w_opc        = inst[6:0];
    assign w_f3         = inst[14:12];
    assign w_size       = size_from_funct3(w_f3);
    assign w_mask       = w_size[2:0] - 3'd1;
    assign w_off        = aluin[c_OFFW-1:0];
    assign w_misaligned = (aluin[2:0] & w_mask) != 3'd0;
    assign w_tmo        = (TIMEOUT != 0) && (tcnt_q == c_TLIM);
    assign w_unused     = ^inst[11:7];

    always_comb begin
        w_illegal = 1'b0;
        if (w_opc == OPC_LOAD) begin
            case (w_f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: w_illegal = 1'b0;
                F3_D, F3_WU:                    w_illegal = (XLEN != 64);
                default:                        w_illegal = 1'b1;
            endcase
        end else if (w_opc == OPC_STORE) begin
            case (w_f3)
                F3_B, F3_H, F3_W: w_illegal = 1'b0;
                F3_D:             w_illegal = (XLEN != 64);
                default:          w_illegal = 1'b1;
            endcase
        end
    end

    // Store data repeats its low S bytes so every lane sees the right byte.
    always_comb begin
        w_be    = '0;
        w_wdata = '0;
        for (int i = 0; i < c_NBYTES; i++) begin
            w_be[i]          = (i >= int'(w_off)) && (i < int'(w_off) + int'(w_size));
            w_wdata[8*i +: 8] = rs2_data[8*(i & int'(w_mask)) +: 8];
        end
    end

    lsu_load_align #(.XLEN(XLEN), .OFFW(c_OFFW)) u_align (
        .rdata_i  (mem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .wb_o     (w_load_wb)
    );

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        werf_d  = 1'b0;
        fault_d = 1'b0;
        cause_d = cause_q;
        wb_d    = wb_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    state_d = ST_DONE;
                    case (w_opc)
                        OPC_LUI: begin
                            werf_d = 1'b1;
                            wb_d   = XLEN'($signed({inst[31:12], 12'b0}));
                        end
                        OPC_OP, OPC_OPIMM: begin
                            werf_d = 1'b1;
                            wb_d   = aluin;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            if (w_illegal) begin
                                fault_d = 1'b1;
                                cause_d = FC_ILLEGAL;
                            end else if (w_misaligned) begin
                                fault_d = 1'b1;
                                cause_d = FC_MISALIGN;
                            end else begin
                                state_d = ST_REQ;
                                tcnt_d  = '0;
                                addr_d  = {aluin[XLEN-1:c_OFFW], {c_OFFW{1'b0}}};
                                be_d    = w_be;
                                wdata_d = w_wdata;
                                we_d    = (w_opc == OPC_STORE);
                                f3_d    = w_f3;
                                off_d   = w_off;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else if (mem_rvalid) begin
                        state_d = ST_DONE;
                        werf_d  = 1'b1;
                        wb_d    = w_load_wb;
                    end else begin
                        state_d = ST_WAIT;
                        tcnt_d  = '0;
                    end
                end else if (w_tmo) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    cause_d = FC_TIMEOUT;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ST_DONE;
                    werf_d  = 1'b1;
                    wb_d    = w_load_wb;
                end else if (w_tmo) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                    cause_d = FC_TIMEOUT;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cause_q <= FC_MISALIGN;
            tcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wb_q    <= '0;
            be_q    <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            werf_q  <= 1'b0;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tcnt_q  <= tcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wb_q    <= wb_d;
            be_q    <= be_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            werf_q  <= werf_d;
            fault_q <= fault_d;
            done_q  <= (state_d == ST_DONE);
            req_q   <= (state_d == ST_REQ);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign busy        = busy_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign done        = done_q;
    assign werf        = werf_q;
    assign wb_data     = wb_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit (XLEN=32)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] inst, aluin, rs2_data;
    logic        busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [3:0]  mem_be;
    logic        mem_ready, mem_rvalid;
    logic        done, werf, fault;
    logic [1:0]  fault_cause;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .inst(inst),
        .aluin(aluin), .rs2_data(rs2_data), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .done(done),
        .werf(werf), .wb_data(wb_data), .fault(fault),
        .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] r);
        valid_in = 1'b1;
        inst     = i;
        aluin    = a;
        rs2_data = r;
        step();
        valid_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; inst = '0; aluin = '0; rs2_data = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0000;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_werf_fault", {30'd0, werf, fault}, 32'd0);
        chk("rst_addr_be", mem_addr | {28'd0, mem_be}, 32'd0);
        chk("rst_wdata_wb", mem_wdata | wb_data, 32'd0);
        chk("rst_cause", {30'd0, fault_cause}, 32'd0);
        step();
        chk("stale_rvalid_idle", {30'd0, done, busy}, 32'd0);
        mem_rvalid = 1'b0;

        // LUI
        issue(32'h1234_5037, 32'h0, 32'h0);
        chk("lui_done", {31'd0, done}, 32'd1);
        chk("lui_werf", {31'd0, werf}, 32'd1);
        chk("lui_wb", wb_data, 32'h1234_5000);
        chk("lui_noreq", {31'd0, mem_req}, 32'd0);
        step();
        chk("lui_idle", {30'd0, done, busy}, 32'd0);

        // SB with ready delayed two cycles
        issue(32'h0000_0023, 32'h0000_1003, 32'h0000_00AB);
        chk("sb_req", {30'd0, mem_req, mem_we}, 32'd3);
        chk("sb_addr", mem_addr, 32'h0000_1000);
        chk("sb_be", {28'd0, mem_be}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        step();
        chk("sb_stall1", {30'd0, mem_req, done}, 32'd2);
        step();
        chk("sb_stall2", {30'd0, mem_req, done}, 32'd2);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("sb_done", {29'd0, done, werf, mem_req}, 32'd4);
        chk("sb_nofault", {31'd0, fault}, 32'd0);
        step();

        // SH lane replication
        issue(32'h0000_1023, 32'h0000_3002, 32'h1234_BEEF);
        chk("sh_be", {28'd0, mem_be}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("sh_done", {31'd0, done}, 32'd1);
        step();

        // LB with rvalid in the ready cycle
        issue(32'h0000_0003, 32'h0000_2002, 32'h0);
        chk("lb_req", {30'd0, mem_req, mem_we}, 32'd2);
        chk("lb_addr_be", mem_addr | {28'd0, mem_be}, 32'h0000_2004);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h00F0_0000;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk("lb_done_werf", {30'd0, done, werf}, 32'd3);
        chk("lb_wb", wb_data, 32'hFFFF_FFF0);
        step();

        // LBU, same stimulus
        issue(32'h0000_4003, 32'h0000_2002, 32'h0);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h00F0_0000;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk("lbu_done", {31'd0, done}, 32'd1);
        chk("lbu_wb", wb_data, 32'h0000_00F0);
        step();

        // LHU via WAIT, rvalid one cycle after ready
        issue(32'h0000_5003, 32'h0000_0022, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("lhu_wait", {29'd0, busy, mem_req, done}, 32'd4);
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
        step();
        mem_rvalid = 1'b0;
        chk("lhu_done", {30'd0, done, werf}, 32'd3);
        chk("lhu_wb", wb_data, 32'h0000_8001);
        step();

        // Misaligned LW
        issue(32'h0000_2003, 32'h0000_2001, 32'h0);
        chk("lw_mis_done_fault", {29'd0, done, fault, werf}, 32'd6);
        chk("lw_mis_cause", {30'd0, fault_cause}, 32'd0);
        chk("lw_mis_noreq", {31'd0, mem_req}, 32'd0);
        step();

        // LD at XLEN=32 is illegal, and illegal outranks misaligned
        issue(32'h0000_3003, 32'h0000_2001, 32'h0);
        chk("ld_illegal_fault", {30'd0, done, fault}, 32'd3);
        chk("ld_illegal_cause", {30'd0, fault_cause}, 32'd1);
        step();
        chk("fault_pulse", {31'd0, fault}, 32'd0);

        // OP and an unrecognised opcode
        issue(32'h0000_0033, 32'hDEAD_BEEF, 32'h0);
        chk("op_wb", wb_data, 32'hDEAD_BEEF);
        chk("op_werf", {30'd0, done, werf}, 32'd3);
        step();
        issue(32'h0000_006F, 32'h0, 32'h0);
        chk("other_op", {29'd0, done, werf, fault}, 32'd4);
        step();

        // Timeout in WAIT after four cycles, late rvalid ignored
        issue(32'h0000_2003, 32'h0000_4000, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step(); step(); step();
        chk("tmo_not_yet", {30'd0, busy, done}, 32'd2);
        step();
        chk("tmo_done_fault", {29'd0, done, fault, werf}, 32'd6);
        chk("tmo_cause", {30'd0, fault_cause}, 32'd2);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        mem_rvalid = 1'b0;
        chk("late_rvalid", {30'd0, done, busy}, 32'd0);

        // Reset during WAIT, then LH
        issue(32'h0000_2003, 32'h0000_5000, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait", {29'd0, busy, mem_req, done}, 32'd0);
        step();
        chk("rst_no_done", {31'd0, done}, 32'd0);
        issue(32'h0000_1003, 32'h0000_0010, 32'h0);
        chk("lh_addr_be", mem_addr | {28'd0, mem_be}, 32'h0000_0013);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_8001;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk("lh_wb", wb_data, 32'hFFFF_8001);
        chk("lh_done", {30'd0, done, werf}, 32'd3);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
